mem_bist: RTL and testbench
===========================

# mem_bist

Parametrised, synthesizable memory built-in self-test engine that drives the single-port memory interface (read/write strobes, address, data in/out) directly from hardware in place of a task-driven bench. On `start` it runs up to three back-to-back phases over every address: clear-to-zero, data-equals-address, and LFSR pseudo-random pattern. Each phase writes the whole array, then reads it back and compares. It sits between the memory under test and a top-level status/CPU register block. It reports pass/fail, plus the first failing address, phase, and data.

## Interface
- `ADDR_WIDTH`, 5: address width; depth `DEPTH = 2**ADDR_WIDTH`.
- `DATA_WIDTH`, 8: memory word width; legal range 1..16.
- `LFSR_SEED`, 16'hACE1: random-phase seed; a value of 0 is replaced by 16'hACE1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE/DONE.
- `busy` out 1: test in progress.
- `done` out 1: level; test finished, held until next accepted `start`.
- `pass` out 1: valid while `done`; 1 means no miscompare.
- `fail_phase` out 2: phase of first miscompare (0 clear, 1 addr, 2 random).
- `fail_addr` out ADDR_WIDTH: address of first miscompare.
- `fail_data` out DATA_WIDTH: data read at the failing address.
- `fail_exp` out DATA_WIDTH: data expected at the failing address.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `mem_rdata` in DATA_WIDTH: memory read data, valid one cycle after `mem_read`.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
  - A phase is WRITE → READ → DRAIN.
  - After DRAIN, the engine advances to the next phase or to DONE.
- IDLE/DONE + `start`=1:
  - Clear `done`, `pass`, and all `fail_*` outputs.
  - Set `busy`.
  - Enter WRITE, phase 0, address 0.
- WRITE:
  - `mem_write`=1, `mem_addr`=counter, `mem_wdata`=pattern(phase, addr).
  - The counter increments each cycle.
  - At DEPTH-1, the counter wraps to 0 and the state goes to READ.
- READ:
  - `mem_read`=1 with the address counter, one read per cycle.
  - The address and expected pattern are pipelined one stage.
  - Each cycle, `mem_rdata` is compared against the previous cycle's expected value.
  - At address DEPTH-1, go to DRAIN.
- DRAIN: no strobes; compare the final read.
- Pattern per phase:
  - Phase 0: all zeros.
  - Phase 1: address zero-extended to DATA_WIDTH, or truncated to its low DATA_WIDTH bits if narrower.
  - Phase 2: low DATA_WIDTH bits of a 16-bit Fibonacci LFSR, taps 16,14,13,11.
- LFSR handling in phase 2:
  - Loaded with the seed at the start of WRITE and advanced once per write.
  - Reloaded with the seed at the start of READ and advanced once per read, so expected values reproduce the written sequence.
- Miscompare:
  - Capture `fail_phase`, `fail_addr`, `fail_data`, and `fail_exp` from the compare stage.
  - Go to DONE with `pass`=0 the next cycle.
  - Stop on first fail; no further memory accesses.
- After the final phase's DRAIN with no miscompare: DONE, `pass`=1.
- `mem_read` and `mem_write` are never both 1.
- `start` while `busy` is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `fail_*`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0; state IDLE.
- `busy` rises the cycle after `start` is sampled.
- Each phase takes exactly 2·DEPTH+1 cycles.
- Passing run: `busy` is high for exactly N·(2·DEPTH+1) cycles, where N is the number of phases (3, or 2 without random).
  - `done` and `pass` rise in the same cycle `busy` falls.
- Failing run: `done` rises 1 cycle after the compare cycle that detected the mismatch; `busy` falls in that same cycle.
- `rst` mid-test: immediate return to IDLE with all outputs at reset values. Memory contents are undefined afterwards.
- `start` asserted in the same cycle as `rst` is lost.

## Configuration
- `MEM_BIST_RAND_EN` defined:
  - Phase 2 (LFSR) and the LFSR logic are compiled in; 3 phases run.
- `MEM_BIST_RAND_EN` undefined:
  - No LFSR; the engine goes to DONE after phase 1; 2 phases run.
  - `fail_phase` never reports 2.

## Test plan
- Fault-free memory, defaults, macro defined:
  - `start` → `busy` high for 195 cycles.
  - Then `done`=1, `pass`=1, `fail_*`=0.
- Same bench with macro undefined:
  - `busy` high for 130 cycles.
  - Then `done`=1, `pass`=1.
- Memory with bit 3 of address 5 stuck at 1:
  - `pass`=0, `fail_phase`=0, `fail_addr`=5, `fail_exp`=8'h00, `fail_data`=8'h08.
- Memory whose writes to address 17 are dropped (ignored) during phase 1 only:
  - `fail_phase`=1, `fail_addr`=17, `fail_exp`=8'h11, `fail_data`=8'h00.
- Repeated runs:
  - `rst` pulsed at cycle 70 of a run → all outputs at reset values next cycle.
  - A fresh `start` then gives a full passing run.
  - A second `start` during `busy` has no effect on cycle count.
- `ADDR_WIDTH`=3, `DATA_WIDTH`=2, macro defined:
  - Passing run with `busy` high for 51 cycles.
  - Phase-1 write data sequence is 0,1,2,3,0,1,2,3.

Source files
------------

// File: rtl/mem_bist.sv
// mem_bist: clear / address / LFSR march self-test for a single-port memory.
// Define MEM_BIST_RAND_EN to compile in the third (LFSR pattern) phase.
module mem_bist #(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_phase,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

`ifdef MEM_BIST_RAND_EN
  localparam logic [1:0]  LAST_PHASE = 2'd2;
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
`else
  localparam logic [1:0]  LAST_PHASE = 2'd1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [1:0]            r_phase;
  logic                  r_cmp_vld;
  logic [DATA_WIDTH-1:0] r_exp_q;
  logic                  r_pass;
  logic [1:0]            r_fail_phase;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_data;
  logic [DATA_WIDTH-1:0] r_fail_exp;

  logic                  w_start_run;
  logic                  w_next_phase;
  logic                  w_set_pass;
  logic                  w_miscmp;
  logic                  w_last_addr;
  logic                  w_step;
  logic [DATA_WIDTH-1:0] w_addr_pat;
  logic [DATA_WIDTH-1:0] w_pat;

  assign w_last_addr = (r_addr == LAST_ADDR);
  assign w_step      = (r_state == S_WRITE) || (r_state == S_READ);
  assign w_miscmp    = r_cmp_vld && (mem_rdata != r_exp_q);

  generate
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_addr_ext
      assign w_addr_pat = DATA_WIDTH'(r_addr);
    end else begin : g_addr_trunc
      assign w_addr_pat = r_addr[DATA_WIDTH-1:0];
    end
  endgenerate

`ifdef MEM_BIST_RAND_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci taps 16,14,13,11 in right-shift form.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Reseed at each WRITE and READ entry so READ replays the written stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else if (w_start_run || w_next_phase ||
                 ((r_state == S_WRITE) && w_last_addr)) begin
      r_lfsr <= SEED;
    end else if (w_step) begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end
`endif

  always_comb begin
    w_pat = '0;
    if (r_phase == 2'd1) begin
      w_pat = w_addr_pat;
    end
`ifdef MEM_BIST_RAND_EN
    else if (r_phase == 2'd2) begin
      w_pat = r_lfsr[DATA_WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_run  = 1'b0;
    w_next_phase = 1'b0;
    w_set_pass   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_WRITE;
          w_start_run = 1'b1;
        end
      end
      S_WRITE: begin
        if (w_last_addr) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (w_miscmp) begin
          w_state_nxt = S_DONE;
        end else if (w_last_addr) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_miscmp) begin
          w_state_nxt = S_DONE;
        end else if (r_phase == LAST_PHASE) begin
          w_state_nxt = S_DONE;
          w_set_pass  = 1'b1;
        end else begin
          w_state_nxt  = S_WRITE;
          w_next_phase = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_addr_q     <= '0;
      r_phase      <= '0;
      r_cmp_vld    <= 1'b0;
      r_exp_q      <= '0;
      r_pass       <= 1'b0;
      r_fail_phase <= '0;
      r_fail_addr  <= '0;
      r_fail_data  <= '0;
      r_fail_exp   <= '0;
    end else begin
      r_cmp_vld <= (r_state == S_READ) && (w_state_nxt != S_DONE);
      r_exp_q   <= w_pat;
      r_addr_q  <= r_addr;

      if (w_start_run) begin
        r_addr <= '0;
      end else if (w_step) begin
        r_addr <= r_addr + 1'b1;
      end

      if (w_start_run) begin
        r_phase <= '0;
      end else if (w_next_phase) begin
        r_phase <= r_phase + 2'd1;
      end

      if (w_start_run) begin
        r_pass <= 1'b0;
      end else if (w_set_pass) begin
        r_pass <= 1'b1;
      end

      if (w_start_run) begin
        r_fail_phase <= '0;
        r_fail_addr  <= '0;
        r_fail_data  <= '0;
        r_fail_exp   <= '0;
      end else if (w_miscmp) begin
        r_fail_phase <= r_phase;
        r_fail_addr  <= r_addr_q;
        r_fail_data  <= mem_rdata;
        r_fail_exp   <= r_exp_q;
      end
    end
  end

  assign busy       = (r_state == S_WRITE) ||
                      (r_state == S_READ)  ||
                      (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign pass       = r_pass;
  assign fail_phase = r_fail_phase;
  assign fail_addr  = r_fail_addr;
  assign fail_data  = r_fail_data;
  assign fail_exp   = r_fail_exp;
  assign mem_write  = (r_state == S_WRITE);
  assign mem_read   = (r_state == S_READ);
  assign mem_addr   = w_step ? r_addr : '0;
  assign mem_wdata  = mem_write ? w_pat : '0;

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: directed checks of mem_bist against behavioural memories,
// with stuck-bit and dropped-write faults and a small-geometry instance.
module tb_mem_bist;

`ifdef MEM_BIST_RAND_EN
  localparam int NPH = 3;
`else
  localparam int NPH = 2;
`endif
  localparam int RUN  = NPH * (2 * 32 + 1);
  localparam int SRUN = NPH * (2 * 8 + 1);

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy, done, pass;
  logic [1:0] fail_phase;
  logic [4:0] fail_addr;
  logic [7:0] fail_data, fail_exp;
  logic       mem_read, mem_write;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  logic       s_start;
  logic       s_busy, s_done, s_pass;
  logic [1:0] s_fail_phase;
  logic [2:0] s_fail_addr;
  logic [1:0] s_fail_data, s_fail_exp;
  logic       s_mem_read, s_mem_write;
  logic [2:0] s_mem_addr;
  logic [1:0] s_mem_wdata, s_mem_rdata;

  logic [7:0] mem   [32];
  logic [1:0] mem_s [8];
  logic [1:0] s_wlog [$];
  int         fault_mode;
  int         n_overlap;
  int         n_chk, n_pass, n_fail;
  int         n;

  mem_bist u_dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .fail_phase(fail_phase), .fail_addr(fail_addr),
    .fail_data(fail_data), .fail_exp(fail_exp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_bist #(.ADDR_WIDTH(3), .DATA_WIDTH(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .fail_phase(s_fail_phase), .fail_addr(s_fail_addr),
    .fail_data(s_fail_data), .fail_exp(s_fail_exp),
    .mem_read(s_mem_read), .mem_write(s_mem_write),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(s_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fault 1: bit 3 of address 5 reads as 1. Fault 2: the 0x11 write to 17 is lost.
  always @(posedge clk) begin
    if (mem_write) begin
      if (!(fault_mode == 2 && mem_addr == 5'd17 && mem_wdata == 8'h11))
        mem[mem_addr] <= mem_wdata;
    end
    if (mem_read) begin
      if (fault_mode == 1 && mem_addr == 5'd5)
        mem_rdata <= mem[mem_addr] | 8'h08;
      else
        mem_rdata <= mem[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (s_mem_write) begin
      mem_s[s_mem_addr] <= s_mem_wdata;
      s_wlog.push_back(s_mem_wdata);
    end
    if (s_mem_read) s_mem_rdata <= mem_s[s_mem_addr];
  end

  always @(negedge clk) begin
    if ((mem_read && mem_write) || (s_mem_read && s_mem_write))
      n_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_pass"},  32'(pass), 0);
    chk({tag, "_fph"},   32'(fail_phase), 0);
    chk({tag, "_faddr"}, 32'(fail_addr), 0);
    chk({tag, "_fdata"}, 32'(fail_data), 0);
    chk({tag, "_fexp"},  32'(fail_exp), 0);
    chk({tag, "_rd"},    32'(mem_read), 0);
    chk({tag, "_wr"},    32'(mem_write), 0);
    chk({tag, "_addr"},  32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; n_overlap = 0;
    fault_mode = 0;
    rst = 1'b1; start = 1'b0; s_start = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;

    // Fault-free full run.
    pulse_start();
    chk("busy_rise", 32'(busy), 1);
    count_busy(n);
    chk("pass_cycles", 32'(n), 32'(RUN));
    chk("pass_done", 32'(done), 1);
    chk("pass_pass", 32'(pass), 1);
    chk("pass_fph", 32'(fail_phase), 0);
    chk("pass_faddr", 32'(fail_addr), 0);
    chk("pass_fdata", 32'(fail_data), 0);
    chk("pass_fexp", 32'(fail_exp), 0);

    // Stuck bit: detected in the phase-0 compare of address 5 (busy cycle 39).
    fault_mode = 1;
    pulse_start();
    count_busy(n);
    chk("stuck_cycles", 32'(n), 39);
    chk("stuck_done", 32'(done), 1);
    chk("stuck_pass", 32'(pass), 0);
    chk("stuck_fph", 32'(fail_phase), 0);
    chk("stuck_faddr", 32'(fail_addr), 5);
    chk("stuck_fexp", 32'(fail_exp), 32'h00);
    chk("stuck_fdata", 32'(fail_data), 32'h08);

    // Dropped phase-1 write: compare of address 17 at busy cycle 65+32+17+2.
    fault_mode = 2;
    pulse_start();
    count_busy(n);
    chk("drop_cycles", 32'(n), 116);
    chk("drop_pass", 32'(pass), 0);
    chk("drop_fph", 32'(fail_phase), 1);
    chk("drop_faddr", 32'(fail_addr), 17);
    chk("drop_fexp", 32'(fail_exp), 32'h11);
    chk("drop_fdata", 32'(fail_data), 32'h00);

    // Reset at cycle 70 of a run, with a start that coincides and is lost.
    fault_mode = 0;
    pulse_start();
    repeat (69) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    start = 1'b1;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_lost", 32'(busy), 0);

    // Fresh run with a start issued while busy.
    pulse_start();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      start = (n == 10);
      @(negedge clk);
    end
    start = 1'b0;
    chk("rerun_cycles", 32'(n), 32'(RUN));
    chk("rerun_done", 32'(done), 1);
    chk("rerun_pass", 32'(pass), 1);

    // Small geometry instance.
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (s_busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("small_cycles", 32'(n), 32'(SRUN));
    chk("small_done", 32'(s_done), 1);
    chk("small_pass", 32'(s_pass), 1);
    chk("small_nwrites", 32'(s_wlog.size()), 32'(NPH * 8));
    for (int i = 0; i < 8; i++)
      chk("small_ph1_wdata", 32'(s_wlog[8 + i]), 32'(i % 4));

    chk("rw_overlap", 32'(n_overlap), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
